// File: rtl/fmc_adc_test_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// fmc_adc_test_pattern_gen_if
// Control and sample bus of the ADC test-pattern generator.
//   master : drives configuration (en, mode, step, bounds, divider, load),
//            receives the sample stream (data, valid, wrap)
//   slave  : the generator itself
// Signals:
//   en_i     generator enable
//   mode_i   00 const, 01 triangle, 10 ramp, 11 PRBS
//   step_i   unsigned increment per sample
//   lower_i  signed lower bound
//   upper_i  signed upper bound
//   div_i    strobe period minus 1
//   load_i   pulse: reinitialise all channel states
//   data_o   ch c at [c*g_WIDTH +: g_WIDTH]
//   valid_o  one-cycle pulse, data_o updated
//   wrap_o   one-cycle pulse on a ch0 reversal / wrap
// ---------------------------------------------------------------------------
interface fmc_adc_test_pattern_gen_if #(
   parameter int g_NB_CH = 4,
   parameter int g_WIDTH = 14
);
   logic                       en_i;
   logic [1:0]                 mode_i;
   logic [g_WIDTH-1:0]         step_i;
   logic [g_WIDTH-1:0]         lower_i;
   logic [g_WIDTH-1:0]         upper_i;
   logic [15:0]                div_i;
   logic                       load_i;
   logic [g_NB_CH*g_WIDTH-1:0] data_o;
   logic                       valid_o;
   logic                       wrap_o;

   modport master (
      output en_i, mode_i, step_i, lower_i, upper_i, div_i, load_i,
      input  data_o, valid_o, wrap_o
   );

   modport slave (
      input  en_i, mode_i, step_i, lower_i, upper_i, div_i, load_i,
      output data_o, valid_o, wrap_o
   );
endinterface

// File: rtl/fmc_adc_test_pattern_gen.sv
// ---------------------------------------------------------------------------
// fmc_adc_test_pattern_gen
// Multi-channel ADC test-pattern generator used in place of deserialised ADC
// data for self-test. Each channel produces a signed g_WIDTH-bit stream
// (constant, triangle, sawtooth ramp or PRBS) at a programmable strobe rate.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset
//   bus    fmc_adc_test_pattern_gen_if slave modport (config in, samples out)
// Parameters:
//   g_NB_CH  channel count (1..8)
//   g_WIDTH  sample width (8..15)
//   g_SEED   PRBS seed base; channel c uses g_SEED[14:0] ^ (c+1), never 0
// ---------------------------------------------------------------------------
module fmc_adc_test_pattern_gen #(
   parameter int          g_NB_CH = 4,
   parameter int          g_WIDTH = 14,
   parameter logic [15:0] g_SEED  = 16'h7FFF
) (
   input logic                       clk_i,
   input logic                       rst_i,
   fmc_adc_test_pattern_gen_if.slave bus
);

   // Two guard bits keep v +/- step free of overflow.
   localparam int SW = g_WIDTH + 2;

   typedef logic signed [SW-1:0] wide_t;

   typedef struct packed {
      logic signed [g_WIDTH-1:0] v;
      logic                      dir;   // 0 = up, 1 = down
      logic                      flip;  // reversal (triangle) or wrap (ramp)
   } upd_t;

   function automatic logic [14:0] seed_of(input int c);
      logic [14:0] s;
      s = g_SEED[14:0] ^ 15'(c + 1);
      if (s == 15'd0) begin
         s = 15'd1;
      end else begin
         s = s;
      end
      return s;
   endfunction

   // x^15 + x^14 + 1, Fibonacci form
   function automatic logic [14:0] lfsr_next(input logic [14:0] s);
      return {s[13:0], s[14] ^ s[13]};
   endfunction

   // One strobe worth of const/triangle/ramp update for a single channel.
   function automatic upd_t chan_update(
      input logic signed [g_WIDTH-1:0] v,
      input logic                      dir,
      input logic [1:0]                mode,
      input logic signed [g_WIDTH-1:0] lo,
      input logic signed [g_WIDTH-1:0] hi,
      input logic [g_WIDTH-1:0]        st
   );
      upd_t  r;
      wide_t vw, low, hiw, up_s, dn_s;
      vw   = {{2{v[g_WIDTH-1]}}, v};
      low  = {{2{lo[g_WIDTH-1]}}, lo};
      hiw  = {{2{hi[g_WIDTH-1]}}, hi};
      up_s = vw + {2'b00, st};
      dn_s = vw - {2'b00, st};
      r.v    = v;
      r.dir  = dir;
      r.flip = 1'b0;
      case (mode)
         2'b00: begin
            r.v = lo;
         end
         2'b01: begin
            if (low > hiw) begin
               r.v = lo;
            end else if (dir == 1'b0) begin
               if (up_s > hiw) begin
                  r.dir  = 1'b1;
                  r.flip = 1'b1;
                  // both directions out of range: hold the value
                  if (dn_s < low) begin
                     r.v = v;
                  end else begin
                     r.v = dn_s[g_WIDTH-1:0];
                  end
               end else begin
                  r.v = up_s[g_WIDTH-1:0];
               end
            end else begin
               if (dn_s < low) begin
                  r.dir  = 1'b0;
                  r.flip = 1'b1;
                  if (up_s > hiw) begin
                     r.v = v;
                  end else begin
                     r.v = up_s[g_WIDTH-1:0];
                  end
               end else begin
                  r.v = dn_s[g_WIDTH-1:0];
               end
            end
         end
         2'b10: begin
            if (low > hiw) begin
               r.v = lo;
            end else if (up_s > hiw) begin
               r.v    = lo;
               r.flip = 1'b1;
            end else begin
               r.v = up_s[g_WIDTH-1:0];
            end
         end
         default: begin
            // PRBS: v and dir hold
            r.v = v;
         end
      endcase
      return r;
   endfunction

   logic [15:0]                cnt_r;
   logic signed [g_WIDTH-1:0]  v_r [g_NB_CH];
   logic                       dir_r [g_NB_CH];
   logic [14:0]                lfsr_r [g_NB_CH];
   logic [g_NB_CH*g_WIDTH-1:0] data_r;
   logic                       valid_r;
   logic                       wrap_r;

   logic [15:0]                cnt_nxt_s;
   logic                       strobe_s;
   logic signed [g_WIDTH-1:0]  lower_s;
   logic signed [g_WIDTH-1:0]  upper_s;
   upd_t                       upd_s;
   int                         ld_sum_s;
   logic signed [g_WIDTH-1:0]  v_upd_s [g_NB_CH];
   logic                       dir_upd_s [g_NB_CH];
   logic [14:0]                lfsr_upd_s [g_NB_CH];
   logic [14:0]                seed_s [g_NB_CH];
   logic signed [g_WIDTH-1:0]  v_ld_s [g_NB_CH];
   logic [g_NB_CH*g_WIDTH-1:0] data_upd_s;
   logic [g_NB_CH*g_WIDTH-1:0] data_ld_s;
   logic                       wrap_upd_s;

   assign lower_s = bus.lower_i;
   assign upper_s = bus.upper_i;

   // Strobe divider: live compare against div_i, restart on overshoot.
   always_comb begin
      cnt_nxt_s = 16'd0;
      strobe_s  = 1'b0;
      if (bus.en_i) begin
         strobe_s = (cnt_r == bus.div_i);
         if (cnt_r >= bus.div_i) begin
            cnt_nxt_s = 16'd0;
         end else begin
            cnt_nxt_s = cnt_r + 16'd1;
         end
      end else begin
         cnt_nxt_s = 16'd0;
         strobe_s  = 1'b0;
      end
   end

   // Per-channel next values for a strobe and for a load.
   always_comb begin
      data_upd_s = {(g_NB_CH*g_WIDTH){1'b0}};
      data_ld_s  = {(g_NB_CH*g_WIDTH){1'b0}};
      wrap_upd_s = 1'b0;
      upd_s      = '{v: {g_WIDTH{1'b0}}, dir: 1'b0, flip: 1'b0};
      ld_sum_s   = 0;
      for (int c = 0; c < g_NB_CH; c++) begin
         upd_s         = chan_update(v_r[c], dir_r[c], bus.mode_i, lower_s, upper_s, bus.step_i);
         v_upd_s[c]    = upd_s.v;
         dir_upd_s[c]  = upd_s.dir;
         lfsr_upd_s[c] = lfsr_next(lfsr_r[c]);
         seed_s[c]     = seed_of(c);
         // initial value lower + c*step, saturated at upper
         ld_sum_s = int'(lower_s) + c * int'(bus.step_i);
         if (ld_sum_s > int'(upper_s)) begin
            v_ld_s[c] = upper_s;
         end else begin
            v_ld_s[c] = ld_sum_s[g_WIDTH-1:0];
         end
         if (c == 0) begin
            wrap_upd_s = upd_s.flip;
         end else begin
            wrap_upd_s = wrap_upd_s;
         end
         if (bus.mode_i == 2'b11) begin
            data_upd_s[c*g_WIDTH +: g_WIDTH] = lfsr_upd_s[c][g_WIDTH-1:0];
            data_ld_s[c*g_WIDTH +: g_WIDTH]  = seed_s[c][g_WIDTH-1:0];
         end else begin
            data_upd_s[c*g_WIDTH +: g_WIDTH] = v_upd_s[c];
            data_ld_s[c*g_WIDTH +: g_WIDTH]  = v_ld_s[c];
         end
      end
   end

   // State and output registers; load takes priority over a strobe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_r   <= 16'd0;
         data_r  <= {(g_NB_CH*g_WIDTH){1'b0}};
         valid_r <= 1'b0;
         wrap_r  <= 1'b0;
         for (int c = 0; c < g_NB_CH; c++) begin
            v_r[c]    <= {g_WIDTH{1'b0}};
            dir_r[c]  <= 1'b0;
            lfsr_r[c] <= seed_of(c);
         end
      end else begin
         cnt_r <= cnt_nxt_s;
         if (bus.load_i) begin
            data_r  <= data_ld_s;
            valid_r <= 1'b0;
            wrap_r  <= 1'b0;
            for (int c = 0; c < g_NB_CH; c++) begin
               v_r[c]    <= v_ld_s[c];
               dir_r[c]  <= 1'b0;
               lfsr_r[c] <= seed_s[c];
            end
         end else if (strobe_s) begin
            data_r  <= data_upd_s;
            valid_r <= 1'b1;
            wrap_r  <= wrap_upd_s;
            for (int c = 0; c < g_NB_CH; c++) begin
               v_r[c]   <= v_upd_s[c];
               dir_r[c] <= dir_upd_s[c];
               if (bus.mode_i == 2'b11) begin
                  lfsr_r[c] <= lfsr_upd_s[c];
               end else begin
                  lfsr_r[c] <= lfsr_r[c];
               end
            end
         end else begin
            valid_r <= 1'b0;
            wrap_r  <= 1'b0;
         end
      end
   end

   assign bus.data_o  = data_r;
   assign bus.valid_o = valid_r;
   assign bus.wrap_o  = wrap_r;

endmodule

// File: tb/tb_fmc_adc_test_pattern_gen.sv
module tb_fmc_adc_test_pattern_gen;
   localparam int NB   = 4;
   localparam int W    = 14;
   localparam int MASK = (1 << W) - 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       load;
   logic [1:0] mode;
   int         step, lower, upper, div;
   int         n_run = 0;
   int         n_fail = 0;

   // reference model state
   int m_cnt;
   int m_v [NB];
   bit m_dir [NB];
   int m_lfsr [NB];
   int m_data [NB];
   bit m_valid, m_wrap;

   always #5 clk = ~clk;

   fmc_adc_test_pattern_gen_if #(.g_NB_CH(NB), .g_WIDTH(W)) bus_if ();

   assign bus_if.en_i    = en;
   assign bus_if.mode_i  = mode;
   assign bus_if.step_i  = W'(step);
   assign bus_if.lower_i = W'(lower);
   assign bus_if.upper_i = W'(upper);
   assign bus_if.div_i   = 16'(div);
   assign bus_if.load_i  = load;

   fmc_adc_test_pattern_gen #(.g_NB_CH(NB), .g_WIDTH(W), .g_SEED(16'h7FFF)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_if)
   );

   function automatic int seed_of(int c);
      int s;
      s = 32'h7FFF ^ (c + 1);
      if (s == 0) s = 1;
      return s;
   endfunction

   function automatic int prbs_next(int s);
      return ((s << 1) & 32'h7FFF) | (((s >> 14) ^ (s >> 13)) & 1);
   endfunction

   function automatic int dut_ch(int c);
      return int'($signed(bus_if.data_o[c*W +: W]));
   endfunction

   function automatic logic [NB*W-1:0] exp_data();
      logic [NB*W-1:0] d;
      for (int c = 0; c < NB; c++) d[c*W +: W] = W'(m_data[c]);
      return d;
   endfunction

   // behavioural model: one clock edge with the inputs currently applied
   task automatic model_tick();
      int nc, v, st;
      bit strobe, flip;
      if (rst) begin
         m_cnt = 0; m_valid = 0; m_wrap = 0;
         for (int c = 0; c < NB; c++) begin
            m_v[c] = 0; m_dir[c] = 0; m_lfsr[c] = seed_of(c); m_data[c] = 0;
         end
      end else begin
         strobe = en && (m_cnt == div);
         nc = (!en || m_cnt >= div) ? 0 : m_cnt + 1;
         m_valid = 0; m_wrap = 0;
         if (load) begin
            for (int c = 0; c < NB; c++) begin
               m_v[c] = lower + c * step;
               if (m_v[c] > upper) m_v[c] = upper;
               m_dir[c] = 0;
               m_lfsr[c] = seed_of(c);
               m_data[c] = (mode == 2'd3) ? (m_lfsr[c] & MASK) : m_v[c];
            end
         end else if (strobe) begin
            m_valid = 1;
            for (int c = 0; c < NB; c++) begin
               v = m_v[c]; st = step; flip = 0;
               case (mode)
                  2'd0: v = lower;
                  2'd1: begin
                     if (lower > upper) v = lower;
                     else if (!m_dir[c]) begin
                        if (v + st > upper) begin
                           flip = 1; m_dir[c] = 1;
                           if (v - st >= lower) v = v - st;
                        end else v = v + st;
                     end else begin
                        if (v - st < lower) begin
                           flip = 1; m_dir[c] = 0;
                           if (v + st <= upper) v = v + st;
                        end else v = v - st;
                     end
                  end
                  2'd2: begin
                     if (lower > upper) v = lower;
                     else if (v + st > upper) begin v = lower; flip = 1; end
                     else v = v + st;
                  end
                  default: m_lfsr[c] = prbs_next(m_lfsr[c]);
               endcase
               m_v[c] = v;
               m_data[c] = (mode == 2'd3) ? (m_lfsr[c] & MASK) : v;
               if (c == 0) m_wrap = flip;
            end
         end
         m_cnt = nc;
      end
   endtask

   task automatic tick();
      model_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b1; en = 1'b1;
      tick(); tick();
      load = 1'b0;
      n_run++;
      if (bus_if.data_o !== '0 || bus_if.valid_o !== 1'b0 || bus_if.wrap_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: data=%h valid=%b wrap=%b, expected 0 0 0", bus_if.data_o, bus_if.valid_o, bus_if.wrap_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_triangle();
      int ns = 0, nw = 0, first = 0, last = 0, bad = 0;
      mode = 2'd1; step = 8; lower = -400; upper = 400; div = 0; en = 1'b1;
      load = 1'b1; tick(); load = 1'b0;
      n_run++;
      if (dut_ch(0) !== -400 || dut_ch(1) !== -392 || bus_if.valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL tri_load: ch0=%0d ch1=%0d valid=%b, expected -400 -392 0", dut_ch(0), dut_ch(1), bus_if.valid_o);
      end
      for (int i = 0; i < 420; i++) begin
         tick();
         n_run++;
         if (bus_if.data_o !== exp_data() || bus_if.valid_o !== m_valid || bus_if.wrap_o !== m_wrap) begin
            n_fail++;
            $display("FAIL triangle: data=%h v=%b w=%b, expected %h %b %b", bus_if.data_o, bus_if.valid_o, bus_if.wrap_o, exp_data(), m_valid, m_wrap);
         end
         if (bus_if.valid_o) ns++;
         if (bus_if.wrap_o) begin
            nw++;
            if (last != 0 && ns - last != 100) bad++;
            if (first == 0) first = ns;
            last = ns;
         end
      end
      n_run++;
      if (nw !== 4 || first !== 101 || bad !== 0) begin
         n_fail++;
         $display("FAIL tri_period: wraps=%0d first=%0d bad=%0d, expected 4 101 0", nw, first, bad);
      end
   endtask

   task automatic test_ramp();
      int e;
      mode = 2'd2; step = 8; lower = 0; upper = 31; div = 0; en = 1'b1;
      load = 1'b1; tick(); load = 1'b0;
      n_run++;
      if (dut_ch(0) !== 0 || dut_ch(1) !== 8 || dut_ch(2) !== 16 || dut_ch(3) !== 24) begin
         n_fail++;
         $display("FAIL ramp_load: %0d %0d %0d %0d, expected 0 8 16 24", dut_ch(0), dut_ch(1), dut_ch(2), dut_ch(3));
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         e = ((i + 1) % 4) * 8;
         n_run++;
         if (dut_ch(0) !== e || bus_if.wrap_o !== (e == 0) || bus_if.data_o !== exp_data()) begin
            n_fail++;
            $display("FAIL ramp: ch0=%0d wrap=%b data=%h, expected %0d %b %h", dut_ch(0), bus_if.wrap_o, bus_if.data_o, e, (e == 0), exp_data());
         end
      end
   endtask

   task automatic test_divider();
      int nv = 0, saved_ch0, first_ok = -1;
      logic [NB*W-1:0] saved;
      mode = 2'd2; step = 1; lower = -1000; upper = 1000; div = 3; en = 1'b1;
      load = 1'b1; tick(); load = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n_run++;
         if (bus_if.data_o !== exp_data() || bus_if.valid_o !== m_valid) begin
            n_fail++;
            $display("FAIL div_run: data=%h v=%b, expected %h %b", bus_if.data_o, bus_if.valid_o, exp_data(), m_valid);
         end
         if (bus_if.valid_o) nv++;
      end
      n_run++;
      if (nv !== 10) begin
         n_fail++;
         $display("FAIL div_count: valids=%0d, expected 10", nv);
      end
      saved = bus_if.data_o; saved_ch0 = dut_ch(0);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_run++;
         if (bus_if.valid_o !== 1'b0 || bus_if.data_o !== saved) begin
            n_fail++;
            $display("FAIL div_hold: data=%h v=%b, expected %h 0", bus_if.data_o, bus_if.valid_o, saved);
         end
      end
      en = 1'b1; nv = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_run++;
         if (bus_if.data_o !== exp_data() || bus_if.valid_o !== m_valid) begin
            n_fail++;
            $display("FAIL div_resume: data=%h v=%b, expected %h %b", bus_if.data_o, bus_if.valid_o, exp_data(), m_valid);
         end
         if (bus_if.valid_o) begin
            if (nv == 0) first_ok = dut_ch(0);
            nv++;
         end
      end
      n_run++;
      if (nv !== 5 || first_ok !== saved_ch0 + 1) begin
         n_fail++;
         $display("FAIL div_continue: valids=%0d ch0=%0d, expected 5 %0d", nv, first_ok, saved_ch0 + 1);
      end
   endtask

   task automatic test_prbs();
      logic [W-1:0] s0;
      s0 = W'(seed_of(0) & MASK);
      mode = 2'd3; div = 0; en = 1'b1;
      load = 1'b1; tick(); load = 1'b0;
      n_run++;
      if (bus_if.data_o[W-1:0] !== s0) begin
         n_fail++;
         $display("FAIL prbs_seed: ch0=%h, expected %h", bus_if.data_o[W-1:0], s0);
      end
      for (int i = 1; i <= 32767; i++) begin
         tick();
         n_run++;
         if (bus_if.data_o !== exp_data() || bus_if.valid_o !== 1'b1 || bus_if.wrap_o !== 1'b0) begin
            n_fail++;
            $display("FAIL prbs: data=%h v=%b w=%b, expected %h 1 0", bus_if.data_o, bus_if.valid_o, bus_if.wrap_o, exp_data());
         end
      end
      n_run++;
      if (bus_if.data_o[W-1:0] !== s0) begin
         n_fail++;
         $display("FAIL prbs_period: ch0=%h after 32767 strobes, expected %h", bus_if.data_o[W-1:0], s0);
      end
   endtask

   task automatic test_load_on_strobe();
      int first = 0;
      bit got = 0;
      mode = 2'd1; step = 5; lower = -50; upper = 60; div = 2; en = 1'b1;
      load = 1'b1; tick(); load = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      for (int k = 0; k < 8 && m_cnt != div; k++) tick();
      n_run++;
      if (m_cnt != div) begin
         n_fail++;
         $display("FAIL load_strobe_wait: no strobe cycle found, cnt=%0d expected %0d", m_cnt, div);
      end
      load = 1'b1; tick(); load = 1'b0;
      n_run++;
      if (bus_if.valid_o !== 1'b0 || dut_ch(0) !== -50 || dut_ch(1) !== -45) begin
         n_fail++;
         $display("FAIL load_strobe: v=%b ch0=%0d ch1=%0d, expected 0 -50 -45", bus_if.valid_o, dut_ch(0), dut_ch(1));
      end
      for (int i = 0; i < 9; i++) begin
         tick();
         n_run++;
         if (bus_if.data_o !== exp_data() || bus_if.valid_o !== m_valid || bus_if.wrap_o !== m_wrap) begin
            n_fail++;
            $display("FAIL load_resume: data=%h v=%b, expected %h %b", bus_if.data_o, bus_if.valid_o, exp_data(), m_valid);
         end
         if (bus_if.valid_o && !got) begin first = dut_ch(0); got = 1; end
      end
      n_run++;
      if (first !== -45) begin
         n_fail++;
         $display("FAIL load_first: ch0=%0d, expected -45", first);
      end
   endtask

   task automatic test_reset_mid();
      mode = 2'd1; step = 3; lower = -30; upper = 30; div = 0; en = 1'b1;
      load = 1'b1; tick(); load = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      rst = 1'b1; load = 1'b1; tick();
      n_run++;
      if (bus_if.data_o !== '0 || bus_if.valid_o !== 1'b0 || bus_if.wrap_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: data=%h v=%b w=%b, expected 0 0 0", bus_if.data_o, bus_if.valid_o, bus_if.wrap_o);
      end
      rst = 1'b0; load = 1'b0;
      tick();
      n_run++;
      if (dut_ch(0) !== 3 || dut_ch(1) !== 3 || bus_if.valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_restart: ch0=%0d ch1=%0d v=%b, expected 3 3 1", dut_ch(0), dut_ch(1), bus_if.valid_o);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         n_run++;
         if (bus_if.data_o !== exp_data() || bus_if.valid_o !== m_valid || bus_if.wrap_o !== m_wrap) begin
            n_fail++;
            $display("FAIL reset_run: data=%h, expected %h", bus_if.data_o, exp_data());
         end
      end
   endtask

   task automatic test_bad_bounds();
      lower = 100; upper = 50; step = 7; div = 0; en = 1'b1;
      mode = 2'd0; load = 1'b1; tick(); load = 1'b0;
      for (int m = 0; m < 3; m++) begin
         mode = 2'(m);
         for (int i = 0; i < 5; i++) begin
            tick();
            n_run++;
            if (dut_ch(0) !== 100 || dut_ch(NB-1) !== 100 || bus_if.wrap_o !== 1'b0 || bus_if.data_o !== exp_data()) begin
               n_fail++;
               $display("FAIL bad_bounds mode%0d: ch0=%0d ch3=%0d w=%b, expected 100 100 0", m, dut_ch(0), dut_ch(NB-1), bus_if.wrap_o);
            end
         end
      end
   endtask

   task automatic test_wide_step();
      mode = 2'd1; lower = 0; upper = 4; step = 8; div = 0; en = 1'b1;
      load = 1'b1; tick(); load = 1'b0;
      n_run++;
      if (dut_ch(0) !== 0 || dut_ch(1) !== 4) begin
         n_fail++;
         $display("FAIL wide_load: ch0=%0d ch1=%0d, expected 0 4", dut_ch(0), dut_ch(1));
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         n_run++;
         if (dut_ch(0) !== 0 || bus_if.wrap_o !== 1'b1 || bus_if.valid_o !== 1'b1 || bus_if.data_o !== exp_data()) begin
            n_fail++;
            $display("FAIL wide_step: ch0=%0d w=%b v=%b, expected 0 1 1", dut_ch(0), bus_if.wrap_o, bus_if.valid_o);
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 30; r++) begin
         mode  = 2'($urandom_range(3));
         step  = int'($urandom_range(400));
         lower = int'($urandom_range(6000)) - 3000;
         upper = int'($urandom_range(6000)) - 3000;
         div   = int'($urandom_range(3));
         load  = 1'($urandom_range(1));
         for (int i = 0; i < 50; i++) begin
            en = ($urandom_range(7) != 0);
            if (i == 25 && $urandom_range(1) == 1) begin
               lower = int'($urandom_range(6000)) - 3000;
               upper = int'($urandom_range(6000)) - 3000;
               mode  = 2'($urandom_range(3));
            end
            tick();
            load = ($urandom_range(30) == 0);
            n_run++;
            if (bus_if.data_o !== exp_data() || bus_if.valid_o !== m_valid || bus_if.wrap_o !== m_wrap) begin
               n_fail++;
               $display("FAIL random r%0d i%0d: data=%h v=%b w=%b, expected %h %b %b", r, i, bus_if.data_o, bus_if.valid_o, bus_if.wrap_o, exp_data(), m_valid, m_wrap);
            end
         end
         load = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; mode = 2'd0;
      step = 0; lower = 0; upper = 0; div = 0;
      test_reset();
      test_triangle();
      test_ramp();
      test_divider();
      test_prbs();
      test_load_on_strobe();
      test_reset_mid();
      test_bad_bounds();
      test_wide_step();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
